control_fsm: RTL and testbench

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/control_fsm.sv | 203 ++++++++++++++++++++
 tb/tb_control_fsm.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_fsm.sv
// control_fsm: multicycle datapath controller (Moore FSM).
// Outputs decode only from the registered state and the held instruction word.
// Build option: define CTRL_ILLEGAL_TRAP_EN to send undefined opcodes to HALT
// instead of treating them as a two-cycle no-op.
module control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IReg_out,
  output logic        PCWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        ALUSrcA,
  output logic        RegWrite,
  output logic        LUI,
  output logic        SWB,
  output logic [1:0]  PCSource,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  BranchType,
  output logic [3:0]  ALUOp,
  output logic [3:0]  state,
  output logic        halted
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_ALU_WB = 4'd5,
    S_MEM_RD = 4'd6,
    S_LW_WB  = 4'd7,
    S_MEM_WR = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_LUI_EX = 4'd11,
    S_LUI_WB = 4'd12,
    S_HALT   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_ANDI  = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b000011;
  localparam logic [5:0] OP_LUI   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b000101;
  localparam logic [5:0] OP_SW    = 6'b000110;
  localparam logic [5:0] OP_J     = 6'b000111;
  localparam logic [5:0] OP_BEQ   = 6'b001000;
  localparam logic [5:0] OP_BNE   = 6'b001001;
  localparam logic [5:0] OP_BLT   = 6'b001010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  state_t     cur_state;
  state_t     nxt_state;
  logic [5:0] opcode;
  logic [3:0] funct;
  logic       is_branch_op;
  logic       unused_ir_bits;

  assign opcode         = IReg_out[31:26];
  assign funct          = IReg_out[3:0];
  assign is_branch_op   = (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_BLT);
  assign unused_ir_bits = ^IReg_out[25:4];
  assign state          = cur_state;

  // State register with synchronous reset to IDLE.
  always_ff @(posedge clk) begin
    if (reset) cur_state <= S_IDLE;
    else       cur_state <= nxt_state;
  end

  // Next-state selection and Moore output decode.
  always_comb begin
    nxt_state  = cur_state;
    PCWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    RegWrite   = 1'b0;
    LUI        = 1'b0;
    SWB        = 1'b0;
    PCSource   = 2'b00;
    ALUSrcB    = 2'b00;
    BranchType = 3'b000;
    ALUOp      = ALU_ADD;
    halted     = 1'b0;

    unique case (cur_state)
      S_IDLE: nxt_state = S_FETCH;

      S_FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcB   = 2'b01;
        nxt_state = S_DECODE;
      end

      S_DECODE: begin
        SWB = (opcode == OP_SW) || is_branch_op;
        unique case (opcode)
          OP_RTYPE:              nxt_state = S_EXEC_R;
          OP_ADDI, OP_ANDI,
          OP_ORI:                nxt_state = S_EXEC_I;
          OP_LUI:                nxt_state = S_LUI_EX;
          OP_LW:                 nxt_state = S_MEM_RD;
          OP_SW:                 nxt_state = S_MEM_WR;
          OP_J:                  nxt_state = S_JUMP;
          OP_BEQ, OP_BNE,
          OP_BLT:                nxt_state = S_BRANCH;
          OP_HALT:               nxt_state = S_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:               nxt_state = S_HALT;
`else
          default:               nxt_state = S_FETCH;
`endif
        endcase
      end

      S_EXEC_R: begin
        ALUSrcA   = 1'b1;
        ALUOp     = funct;
        nxt_state = S_ALU_WB;
      end

      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        if (opcode == OP_ADDI) begin
          ALUSrcB = 2'b10;
          ALUOp   = ALU_ADD;
        end else begin
          ALUSrcB = 2'b11;
          ALUOp   = (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
        end
        nxt_state = S_ALU_WB;
      end

      S_ALU_WB: begin
        RegWrite  = 1'b1;
        nxt_state = S_FETCH;
      end

      S_LUI_EX: begin
        ALUSrcB   = 2'b11;
        ALUOp     = ALU_PASSB;
        LUI       = 1'b1;
        nxt_state = S_LUI_WB;
      end

      S_LUI_WB: begin
        RegWrite  = 1'b1;
        LUI       = 1'b1;
        nxt_state = S_FETCH;
      end

      S_MEM_RD: begin
        MemRead   = 1'b1;
        nxt_state = S_LW_WB;
      end

      S_LW_WB: begin
        MemtoReg  = 1'b1;
        RegWrite  = 1'b1;
        nxt_state = S_FETCH;
      end

      S_MEM_WR: begin
        SWB       = 1'b1;
        MemWrite  = 1'b1;
        nxt_state = S_FETCH;
      end

      S_BRANCH: begin
        SWB        = 1'b1;
        BranchType = {1'b0, opcode[1:0]} + 3'd1;
        nxt_state  = S_FETCH;
      end

      S_JUMP: begin
        PCWrite   = 1'b1;
        PCSource  = 2'b10;
        nxt_state = S_FETCH;
      end

      S_HALT: begin
        halted    = 1'b1;
        nxt_state = S_HALT;
      end

      default: nxt_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// Testbench for control_fsm: per-instruction expected control traces are built
// from the instruction's class and compared cycle by cycle.
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IReg_out;
  logic        PCWrite, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA;
  logic        RegWrite, LUI, SWB, halted;
  logic [1:0]  PCSource, ALUSrcB;
  logic [2:0]  BranchType;
  logic [3:0]  ALUOp, state;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, memr, memw, irw, m2r, asa, regw, lui, swb;
    logic [1:0] pcsrc, asb;
    logic [2:0] bt;
    logic [3:0] aluop;
    logic       halted;
  } exp_t;

  exp_t act;
  exp_t plan_q[$];

  control_fsm dut (
    .clk(clk), .reset(reset), .IReg_out(IReg_out),
    .PCWrite(PCWrite), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .LUI(LUI), .SWB(SWB),
    .PCSource(PCSource), .ALUSrcB(ALUSrcB), .BranchType(BranchType), .ALUOp(ALUOp),
    .state(state), .halted(halted)
  );

  assign act = {state, PCWrite, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite,
                LUI, SWB, PCSource, ALUSrcB, BranchType, ALUOp, halted};

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t fetch_rec();
    exp_t r = '0;
    r.st = 4'd1; r.irw = 1'b1; r.pcw = 1'b1; r.asb = 2'b01;
    return r;
  endfunction

  // Expected per-cycle trace for one instruction, starting at its fetch cycle.
  task automatic build_plan(input logic [31:0] ir);
    int   op;
    exp_t r;
    op = int'(ir[31:26]);
    plan_q.delete();
    plan_q.push_back(fetch_rec());
    r = '0; r.st = 4'd2; r.swb = (op == 6) || (op >= 8 && op <= 10);
    plan_q.push_back(r);
    if (op == 0) begin
      r = '0; r.st = 4'd3; r.asa = 1'b1; r.aluop = ir[3:0]; plan_q.push_back(r);
      r = '0; r.st = 4'd5; r.regw = 1'b1; plan_q.push_back(r);
    end else if (op >= 1 && op <= 3) begin
      r = '0; r.st = 4'd4; r.asa = 1'b1;
      r.asb   = (op == 1) ? 2'b10 : 2'b11;
      r.aluop = (op == 1) ? 4'd0 : (op == 2) ? 4'd2 : 4'd3;
      plan_q.push_back(r);
      r = '0; r.st = 4'd5; r.regw = 1'b1; plan_q.push_back(r);
    end else if (op == 4) begin
      r = '0; r.st = 4'd11; r.asb = 2'b11; r.aluop = 4'd7; r.lui = 1'b1; plan_q.push_back(r);
      r = '0; r.st = 4'd12; r.regw = 1'b1; r.lui = 1'b1; plan_q.push_back(r);
    end else if (op == 5) begin
      r = '0; r.st = 4'd6; r.memr = 1'b1; plan_q.push_back(r);
      r = '0; r.st = 4'd7; r.m2r = 1'b1; r.regw = 1'b1; plan_q.push_back(r);
    end else if (op == 6) begin
      r = '0; r.st = 4'd8; r.swb = 1'b1; r.memw = 1'b1; plan_q.push_back(r);
    end else if (op == 7) begin
      r = '0; r.st = 4'd10; r.pcw = 1'b1; r.pcsrc = 2'b10; plan_q.push_back(r);
    end else if (op >= 8 && op <= 10) begin
      r = '0; r.st = 4'd9; r.swb = 1'b1; r.bt = 3'(op - 7); plan_q.push_back(r);
    end else if (op == 63) begin
      r = '0; r.st = 4'd15; r.halted = 1'b1; plan_q.push_back(r);
    end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      r = '0; r.st = 4'd15; r.halted = 1'b1; plan_q.push_back(r);
`endif
    end
  endtask

  // Executes one instruction from its FETCH cycle and checks every cycle plus the follow-on state.
  task automatic run_instr(input logic [31:0] ir, input string name);
    exp_t nxt;
    IReg_out = ir;
    build_plan(ir);
    foreach (plan_q[i]) begin
      if (i > 0) step();
      checks++;
      if (act !== plan_q[i]) begin
        errors++;
        $display("FAIL %s cycle %0d ir=%h: got %h expected %h", name, i, ir, act, plan_q[i]);
      end
    end
    step();
    if (plan_q[plan_q.size()-1].st == 4'd15) begin
      nxt = '0; nxt.st = 4'd15; nxt.halted = 1'b1;
    end else begin
      nxt = fetch_rec();
    end
    checks++;
    if (act !== nxt) begin
      errors++;
      $display("FAIL %s_next ir=%h: got %h expected %h", name, ir, act, nxt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    IReg_out = $urandom;
    repeat (3) step();
    checks++;
    if (act !== exp_t'('0)) begin
      errors++;
      $display("FAIL reset_idle: got %h expected %h", act, exp_t'('0));
    end
    reset = 1'b0;
    step();
    checks++;
    if (act !== fetch_rec()) begin
      errors++;
      $display("FAIL reset_first_fetch: got %h expected %h", act, fetch_rec());
    end
  endtask

  task automatic test_directed();
    run_instr(32'h0022_1800, "add_r1_r2_r3");
    run_instr({6'b000101, 10'h0A5, 16'h0010}, "lw");
    run_instr({6'b000110, 26'($urandom)}, "sw");
    run_instr({6'b001001, 26'($urandom)}, "bne");
    run_instr({6'b000111, 26'($urandom)}, "jump");
    run_instr({6'b000100, 26'($urandom)}, "lui");
  endtask

  task automatic test_rtype_funct();
    for (int unsigned f = 0; f < 16; f++)
      run_instr({6'b000000, 22'($urandom), 4'(f)}, "rtype_funct");
  endtask

  task automatic test_itype_branch();
    for (int unsigned op = 1; op <= 3; op++)
      run_instr({6'(op), 26'($urandom)}, "itype");
    for (int unsigned op = 8; op <= 10; op++)
      run_instr({6'(op), 26'($urandom)}, "branch");
  endtask

  task automatic hold_halt_then_reset(input string name);
    exp_t h = '0;
    h.st = 4'd15; h.halted = 1'b1;
    for (int unsigned c = 0; c < 10; c++) begin
      step();
      checks++;
      if (act !== h) begin
        errors++;
        $display("FAIL %s_hold cycle %0d: got %h expected %h", name, c, act, h);
      end
    end
    reset = 1'b1;
    step();
    checks++;
    if (act !== exp_t'('0)) begin
      errors++;
      $display("FAIL %s_reset: got %h expected %h", name, act, exp_t'('0));
    end
    reset = 1'b0;
    step();
    checks++;
    if (act !== fetch_rec()) begin
      errors++;
      $display("FAIL %s_refetch: got %h expected %h", name, act, fetch_rec());
    end
  endtask

  task automatic test_halt();
    run_instr({6'b111111, 26'($urandom)}, "halt");
    hold_halt_then_reset("halt");
  endtask

  task automatic test_illegal();
    run_instr({6'h3E, 26'($urandom)}, "illegal_3e");
    if (plan_q[plan_q.size()-1].st == 4'd15) hold_halt_then_reset("illegal_3e");
  endtask

  task automatic test_reset_mid_instr();
    IReg_out = {6'b000000, 22'($urandom), 4'($urandom)};
    step();
    step();
    checks++;
    if (act.st !== 4'd3) begin
      errors++;
      $display("FAIL mid_reset_reach_exec_r: got %0d expected 3", act.st);
    end
    reset = 1'b1;
    step();
    checks++;
    if (act !== exp_t'('0)) begin
      errors++;
      $display("FAIL mid_reset_idle: got %h expected %h", act, exp_t'('0));
    end
    reset = 1'b0;
    step();
    checks++;
    if (act !== fetch_rec()) begin
      errors++;
      $display("FAIL mid_reset_fetch: got %h expected %h", act, fetch_rec());
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] legal [11] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10};
    logic [5:0] op;
    for (int unsigned n = 0; n < 60; n++) begin
      op = legal[$urandom_range(10, 0)];
`ifndef CTRL_ILLEGAL_TRAP_EN
      if ($urandom_range(7, 0) == 0) op = 6'($urandom_range(62, 11));
`endif
      run_instr({op, 26'($urandom)}, "back_to_back");
    end
  endtask

  initial begin
    reset = 1'b1;
    IReg_out = '0;
    test_reset();
    test_directed();
    test_rtype_funct();
    test_itype_branch();
    test_halt();
    test_illegal();
    test_reset_mid_instr();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
